// File: rtl/regfile_2r1w_if.sv
// rtl/regfile_2r1w_if.sv - write, read and debug signal bundle for regfile_2r1w
interface regfile_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output we, waddr, wdata, re, ra1, ra2, dbg_addr,
        input  rd1, rd2, rvalid, dbg_data
    );

    modport slave (
        input  we, waddr, wdata, re, ra1, ra2, dbg_addr,
        output rd1, rd2, rvalid, dbg_data
    );
endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two-read one-write register file with bypass, zero register and optional registered read
module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int REG_OUT  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_2r1w_if.slave  rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [DATA_W-1:0] rv1;
    logic [DATA_W-1:0] rv2;

    assign wr_en = rf.we && !((ZERO_REG != 0) && (rf.waddr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[rf.waddr] <= rf.wdata;
        end
    end

    // Later assignments win: the zero register overrides the write-through bypass.
    always_comb begin
        rv1 = mem[rf.ra1];
        if (rf.we && (rf.waddr == rf.ra1)) begin
            rv1 = rf.wdata;
        end
        if ((ZERO_REG != 0) && (rf.ra1 == '0)) begin
            rv1 = '0;
        end

        rv2 = mem[rf.ra2];
        if (rf.we && (rf.waddr == rf.ra2)) begin
            rv2 = rf.wdata;
        end
        if ((ZERO_REG != 0) && (rf.ra2 == '0)) begin
            rv2 = '0;
        end
    end

    assign rf.dbg_data = ((ZERO_REG != 0) && (rf.dbg_addr == '0)) ? '0 : mem[rf.dbg_addr];

    if (REG_OUT != 0) begin : g_reg_out
        logic [DATA_W-1:0] rd1_q;
        logic [DATA_W-1:0] rd2_q;
        logic              rvalid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd1_q    <= '0;
                rd2_q    <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rf.re;
                if (rf.re) begin
                    rd1_q <= rv1;
                    rd2_q <= rv2;
                end
            end
        end

        assign rf.rd1    = rd1_q;
        assign rf.rd2    = rd2_q;
        assign rf.rvalid = rvalid_q;
    end else begin : g_comb_out
        logic unused_re;
        assign unused_re = rf.re;

        assign rf.rd1    = rv1;
        assign rf.rd2    = rv2;
        assign rf.rvalid = 1'b1;
    end
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - four regfile_2r1w configurations against one array-based model
module tb_regfile_2r1w;
    localparam int NK = 4;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg_addr;

    int n_pass;
    int n_total;

    regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
    regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
    regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) if2 ();
    regfile_2r1w_if #(.DATA_W(16), .ADDR_W(3)) if3 ();

    assign if0.we = we;  assign if0.waddr = waddr;      assign if0.wdata = wdata;
    assign if0.re = re;  assign if0.ra1 = ra1;          assign if0.ra2 = ra2;
    assign if0.dbg_addr = dbg_addr;
    assign if1.we = we;  assign if1.waddr = waddr;      assign if1.wdata = wdata;
    assign if1.re = re;  assign if1.ra1 = ra1;          assign if1.ra2 = ra2;
    assign if1.dbg_addr = dbg_addr;
    assign if2.we = we;  assign if2.waddr = waddr;      assign if2.wdata = wdata;
    assign if2.re = re;  assign if2.ra1 = ra1;          assign if2.ra2 = ra2;
    assign if2.dbg_addr = dbg_addr;
    assign if3.we = we;  assign if3.waddr = waddr[2:0]; assign if3.wdata = wdata[15:0];
    assign if3.re = re;  assign if3.ra1 = ra1[2:0];     assign if3.ra2 = ra2[2:0];
    assign if3.dbg_addr = dbg_addr[2:0];

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .REG_OUT(0)) u0 (.clk(clk), .rst_n(rst_n), .rf(if0));
    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .REG_OUT(1)) u1 (.clk(clk), .rst_n(rst_n), .rf(if1));
    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .REG_OUT(0)) u2 (.clk(clk), .rst_n(rst_n), .rf(if2));
    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .REG_OUT(1)) u3 (.clk(clk), .rst_n(rst_n), .rf(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dw(int k);    return (k == 3) ? 16 : 32; endfunction
    function automatic int aw(int k);    return (k == 3) ? 3 : 5;   endfunction
    function automatic bit zr(int k);    return (k != 2);           endfunction
    function automatic bit ro(int k);    return (k == 1) || (k == 3); endfunction
    function automatic int amask(int k); return (1 << aw(k)) - 1;   endfunction
    function automatic logic [31:0] dmask(int k);
        return (dw(k) == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << dw(k)) - 64'd1);
    endfunction

    logic [31:0] m [NK][32];
    logic [31:0] e_rd1 [NK];
    logic [31:0] e_rd2 [NK];
    logic        e_rv  [NK];

    function automatic void clear_model();
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < 32; i++) m[k][i] = '0;
            e_rd1[k] = '0;
            e_rd2[k] = '0;
            e_rv[k]  = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rule(int k, logic [4:0] a);
        int am;
        am = int'(a) & amask(k);
        if (zr(k) && am == 0) return '0;
        if (we && ((int'(waddr) & amask(k)) == am)) return wdata & dmask(k);
        return m[k][am];
    endfunction

    function automatic logic [31:0] dbg_model(int k);
        int am;
        am = int'(dbg_addr) & amask(k);
        if (zr(k) && am == 0) return '0;
        return m[k][am];
    endfunction

    function automatic logic [31:0] obs(int k, int sel);
        logic [31:0] v;
        v = '0;
        case (k)
            0: case (sel) 0: v = if0.rd1; 1: v = if0.rd2; 2: v = {31'b0, if0.rvalid}; default: v = if0.dbg_data; endcase
            1: case (sel) 0: v = if1.rd1; 1: v = if1.rd2; 2: v = {31'b0, if1.rvalid}; default: v = if1.dbg_data; endcase
            2: case (sel) 0: v = if2.rd1; 1: v = if2.rd2; 2: v = {31'b0, if2.rvalid}; default: v = if2.dbg_data; endcase
            default: case (sel) 0: v = {16'b0, if3.rd1}; 1: v = {16'b0, if3.rd2}; 2: v = {31'b0, if3.rvalid};
                                default: v = {16'b0, if3.dbg_data}; endcase
        endcase
        return v;
    endfunction

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic check_comb();
        for (int k = 0; k < NK; k++) begin
            if (!ro(k)) begin
                check($sformatf("rd1_comb[%0d] ra1=%0d", k, ra1), obs(k, 0), rule(k, ra1));
                check($sformatf("rd2_comb[%0d] ra2=%0d", k, ra2), obs(k, 1), rule(k, ra2));
                check($sformatf("rvalid_comb[%0d]", k), obs(k, 2), 32'd1);
            end
            check($sformatf("dbg_pre[%0d] addr=%0d", k, dbg_addr), obs(k, 3), dbg_model(k));
        end
    endtask

    task automatic check_reg();
        for (int k = 0; k < NK; k++) begin
            if (ro(k)) begin
                check($sformatf("rd1_reg[%0d]", k), obs(k, 0), e_rd1[k]);
                check($sformatf("rd2_reg[%0d]", k), obs(k, 1), e_rd2[k]);
                check($sformatf("rvalid_reg[%0d]", k), obs(k, 2), {31'b0, e_rv[k]});
            end
            check($sformatf("dbg_post[%0d] addr=%0d", k, dbg_addr), obs(k, 3), dbg_model(k));
        end
    endtask

    // One clock cycle: check settled outputs mid-cycle, advance the model, check after the edge.
    task automatic step();
        int am;
        if (!rst_n) clear_model();
        #4;
        check_comb();
        for (int k = 0; k < NK; k++) begin
            if (ro(k) && rst_n) begin
                if (re) begin
                    e_rd1[k] = rule(k, ra1);
                    e_rd2[k] = rule(k, ra2);
                    e_rv[k]  = 1'b1;
                end else begin
                    e_rv[k] = 1'b0;
                end
            end
        end
        if (rst_n && we) begin
            for (int k = 0; k < NK; k++) begin
                am = int'(waddr) & amask(k);
                if (!(zr(k) && am == 0)) m[k][am] = wdata & dmask(k);
            end
        end
        @(posedge clk);
        #1;
        check_reg();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;

        rst_n = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        re = 1'b1; ra1 = 5'd5; ra2 = 5'd0; dbg_addr = 5'd5;
        @(posedge clk);
        #1;
        clear_model();
        repeat (3) step();

        rst_n = 1'b1; we = 1'b0;
        step();

        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; ra1 = 5'd0; ra2 = 5'd1; dbg_addr = 5'd7;
        step();
        we = 1'b0; ra1 = 5'd7; ra2 = 5'd7; re = 1'b1;
        step();
        re = 1'b0; ra1 = 5'd9;
        step();

        we = 1'b1; waddr = 5'd3; wdata = 32'h1; re = 1'b1;
        step();
        waddr = 5'd3; wdata = 32'hA5A5_A5A5; ra1 = 5'd3; ra2 = 5'd4; dbg_addr = 5'd3;
        step();
        we = 1'b0;
        step();

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; ra1 = 5'd0; dbg_addr = 5'd0;
        step();
        we = 1'b0;
        step();

        for (int i = 1; i < 8; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i * 32'h1111);
            step();
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra1 = 5'(i); ra2 = 5'(7 - i); dbg_addr = 5'(i);
            step();
        end
        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_BEEF;
        step();
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra1 = 5'(i); ra2 = 5'(7 - i); dbg_addr = 5'(i);
            step();
        end

        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_comb();
        check_reg();
        step();
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            we       = $urandom_range(0, 1) == 1;
            waddr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wdata    = $urandom;
            re       = $urandom_range(0, 3) != 0;
            ra1      = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            ra2      = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            dbg_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised general-purpose register file for the CPU datapath. It generalises the fixed 32-entry by 32-bit read-select mux into a full register file with the following features:
- storage
- two read ports
- one write port
- a hardwired zero register
- write-to-read bypass
- an optional registered-read mode with a valid flag

It sits between decode, which supplies read addresses, and writeback, which supplies the write port.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register
- REG_OUT, 0, 0: combinational read (0-cycle latency); 1: registered read (1-cycle latency)

Ports:
- clk, in, 1, clock; all state changes on the rising edge
- rst_n, in, 1, reset, asynchronous, active-low
- we, in, 1, write enable
- waddr, in, ADDR_W, write address
- wdata, in, DATA_W, write data
- re, in, 1, read enable; used only when REG_OUT=1, ignored when REG_OUT=0
- ra1, in, ADDR_W, read address, port 1
- ra2, in, ADDR_W, read address, port 2
- rd1, out, DATA_W, read data, port 1
- rd2, out, DATA_W, read data, port 2
- rvalid, out, 1, read data valid; REG_OUT=1 only, tied 1 when REG_OUT=0
- dbg_addr, in, ADDR_W, debug/monitor read address
- dbg_data, out, DATA_W, debug read data; combinational, no bypass

## Operation
**Storage**
- 2**ADDR_W entries of DATA_W bits.
- rst_n low clears every entry to 0 asynchronously.

**Write**
- Occurs on a rising edge when we=1.
- The entry at waddr takes wdata.
- When ZERO_REG=1 and waddr=0, the write is dropped.

**Read value rule**, applied per port p in {1,2}:
- If ZERO_REG=1 and ra_p=0, the value is 0. This takes precedence over bypass.
- Else, if we=1 and waddr=ra_p, the value is wdata (write-through bypass).
- Else, the value is the stored entry at ra_p.

Both ports may address the same entry; each resolves independently.

**REG_OUT=0**
- rd1/rd2 are combinational functions of the read value rule.
- rvalid is constant 1.

**REG_OUT=1**
- On a rising edge with re=1, rd1/rd2 capture the read value rule as evaluated with that cycle's inputs, and rvalid is set to 1.
- On a rising edge with re=0, rd1/rd2 hold their previous values and rvalid is set to 0.

**Debug port**
- dbg_data is the stored entry at dbg_addr, or 0 for entry 0 when ZERO_REG=1.
- It has no bypass, so a same-cycle write becomes visible only after the edge.

**Out-of-range addresses** cannot occur: depth equals 2**ADDR_W.

## Timing
**Reset values** (asynchronous assert while rst_n=0):
- all entries: 0
- rd1/rd2: 0 when REG_OUT=1; when REG_OUT=0 they reflect the cleared storage, so 0 unless bypass is active
- rvalid: 0 when REG_OUT=1, 1 when REG_OUT=0
- dbg_data: 0

**Reset release and interaction with writes**
- Reset release is synchronous-safe: the first edge with rst_n=1 may perform a write and a read.
- A write with we=1 on an edge where rst_n=0 is lost.
- If reset asserts mid-cycle, stored data and registered outputs clear immediately.

**Latency**
- Write: data is stored at edge N and visible through storage from N onward.
- With bypass, data is visible combinationally in cycle N (REG_OUT=0), or captured into rd at edge N (REG_OUT=1).
- Read with REG_OUT=0: 0 cycles.
- Read with REG_OUT=1: 1 cycle, i.e. addresses presented in cycle N produce data valid after edge N.

**Simultaneous events**
- Write and read of the same address in the same cycle: the read returns the new data (bypass) in both modes.
- Write to entry 0 together with a read of entry 0 (ZERO_REG=1): the read returns 0.

**Loop restriction**: no combinational path from any output back to any input.

## Test plan
1. **Reset**: hold rst_n=0 for 3 cycles with we=1, waddr=5, wdata=0xDEADBEEF → all entries 0, dbg_data at addr 5 is 0; REG_OUT=1: rd1=rd2=0 and rvalid=0.
2. **Basic write/read**: write 0x12345678 to entry 7, then on the next cycle set ra1=7, ra2=7 → rd1=rd2=0x12345678. REG_OUT=1 with re=1: the values appear one edge later with rvalid=1.
3. **Bypass**: entry 3 holds 0x1; in the same cycle drive we=1, waddr=3, wdata=0xA5A5A5A5, ra1=3, ra2=4 → rd1=0xA5A5A5A5 (combinationally, or after the edge when REG_OUT=1), rd2 = stored entry 4; dbg_addr=3 shows 0x1 before the edge and 0xA5A5A5A5 after.
4. **Zero register**:
   - ZERO_REG=1: write 0xFFFFFFFF to entry 0 while ra1=0 → rd1=0 and dbg_data(0)=0 afterwards.
   - ZERO_REG=0: the same sequence yields 0xFFFFFFFF.
5. **Registered hold** (REG_OUT=1): after a read of entry 7, deassert re and change ra1 to 9 → rd1 holds 0x12345678 and rvalid=0 at the next edge.
6. **Parameter sweep**: DATA_W=16, ADDR_W=3; write i*0x1111 to entries 1..7, then read all 8 on both ports → entry 0 reads 0 and entry i reads i*0x1111; rewriting entry 7 wraps no other entry.
